// File: rtl/encrypt_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : encrypt_req_arbiter
// Purpose  : Round-robin frame arbiter, config register owner and output
//            tagger for the shared XOR/rotate encryption pipe.
// Revision : 1.0
// ============================================================================
module encrypt_req_arbiter #(
    parameter int PIPE_LAT = 1,
    parameter int TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [7:0]  cfg_wdata,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_last,
    output logic [1:0]  req_ready,
    output logic        pipe_en,
    output logic [7:0]  pipe_din,
    output logic [7:0]  pipe_k1,
    output logic [7:0]  pipe_k2,
    output logic [7:0]  pipe_k3,
    output logic [2:0]  pipe_rot_freq,
    output logic        pipe_mode,
    output logic        pipe_rst_n,
    input  logic [7:0]  enc_data,
    input  logic        enc_valid,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_id,
    output logic        out_last,
    output logic        abort,
    output logic        cfg_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESTART = 2'd1,
        STREAM  = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_gnt;
    logic                r_pri;
    logic                r_any_acc;
    logic [7:0]          r_idle_cnt;
    logic [1:0]          r_drain_cnt;
    logic [PIPE_LAT-1:0] r_tag_v;
    logic [PIPE_LAT-1:0] r_tag_id;
    logic [PIPE_LAT-1:0] r_tag_last;
    logic                r_abort;
    logic                r_cfg_err;
    logic                r_pipe_rst_n;
    logic [7:0]          r_k1;
    logic [7:0]          r_k2;
    logic [7:0]          r_k3;
    logic [2:0]          r_rot;
    logic                r_mode;

    logic w_stream;
    logic w_valid_g;
    logic w_last_g;
    logic w_accept;
    logic w_timeout;
    logic w_grant;
    logic w_winner;
    logic w_push;
    logic w_push_last;

    assign w_stream    = (r_state == STREAM);
    assign w_valid_g   = req_valid[r_gnt];
    assign w_last_g    = req_last[r_gnt];
    assign w_accept    = w_stream && w_valid_g;
    assign w_timeout   = w_stream && !w_valid_g && (r_idle_cnt == 8'(TIMEOUT - 1));
    assign w_grant     = (r_state == IDLE) && r_mode && (|req_valid);
    assign w_winner    = (&req_valid) ? r_pri : req_valid[1];
    // A timeout closes the frame with a last-only tag; an empty frame has nothing to close.
    assign w_push      = w_accept || (w_timeout && r_any_acc);
    assign w_push_last = w_accept ? w_last_g : 1'b1;

    assign req_ready     = w_stream ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
    assign pipe_en       = w_accept;
    assign pipe_din      = req_data[{r_gnt, 3'b000} +: 8];
    assign pipe_k1       = r_k1;
    assign pipe_k2       = r_k2;
    assign pipe_k3       = r_k3;
    assign pipe_rot_freq = r_rot;
    assign pipe_mode     = r_mode;
    assign pipe_rst_n    = r_pipe_rst_n;
    assign out_valid     = enc_valid;
    assign out_data      = enc_data;
    assign out_id        = r_tag_id[PIPE_LAT-1];
    assign out_last      = r_tag_v[PIPE_LAT-1] && r_tag_last[PIPE_LAT-1];
    assign abort         = r_abort;
    assign cfg_err       = r_cfg_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_gnt        <= 1'b0;
            r_pri        <= 1'b0;
            r_any_acc    <= 1'b0;
            r_idle_cnt   <= 8'd0;
            r_drain_cnt  <= 2'd0;
            r_tag_v      <= '0;
            r_tag_id     <= '0;
            r_tag_last   <= '0;
            r_abort      <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_pipe_rst_n <= 1'b0;
            r_k1         <= 8'd0;
            r_k2         <= 8'd0;
            r_k3         <= 8'd0;
            r_rot        <= 3'd0;
            r_mode       <= 1'b0;
        end else begin
            r_abort   <= 1'b0;
            r_cfg_err <= cfg_we && (r_state != IDLE);

            r_tag_v[0]    <= w_push;
            r_tag_id[0]   <= r_gnt;
            r_tag_last[0] <= w_push_last;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_tag_v[i]    <= r_tag_v[i-1];
                r_tag_id[i]   <= r_tag_id[i-1];
                r_tag_last[i] <= r_tag_last[i-1];
            end

            case (r_state)
                IDLE: begin
                    r_pipe_rst_n <= 1'b1;
                    if (cfg_we) begin
                        case (cfg_addr)
                            2'd0:    r_k1 <= cfg_wdata;
                            2'd1:    r_k2 <= cfg_wdata;
                            2'd2:    r_k3 <= cfg_wdata;
                            default: begin
                                r_mode <= cfg_wdata[3];
                                r_rot  <= cfg_wdata[2:0];
                            end
                        endcase
                    end
                    if (w_grant) begin
                        r_gnt        <= w_winner;
                        r_pipe_rst_n <= 1'b0;
                        r_state      <= RESTART;
                    end
                end
                RESTART: begin
                    r_pipe_rst_n <= 1'b1;
                    r_idle_cnt   <= 8'd0;
                    r_any_acc    <= 1'b0;
                    r_state      <= STREAM;
                end
                STREAM: begin
                    if (w_accept) begin
                        r_idle_cnt <= 8'd0;
                        r_any_acc  <= 1'b1;
                        if (w_last_g) begin
                            r_pri       <= ~r_gnt;
                            r_drain_cnt <= 2'd0;
                            r_state     <= DRAIN;
                        end
                    end else if (w_timeout) begin
                        r_abort     <= 1'b1;
                        r_pri       <= ~r_gnt;
                        r_drain_cnt <= 2'd0;
                        r_state     <= DRAIN;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 8'd1;
                    end
                end
                default: begin
                    if (r_drain_cnt == 2'(PIPE_LAT - 1)) begin
                        r_state <= IDLE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 2'd1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
